// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: drives the instruction-memory address and
// buffers fetched {pc, instr} pairs in a 2-entry queue toward decode.
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'd0,
    parameter logic [31:0] PC_LIMIT = 32'd44
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] IMEM_PC,
    input  logic [31:0] IMEM_instruction,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        fetch_valid,
    input  logic        fetch_ready,
    output logic [31:0] fetch_instr,
    output logic [31:0] fetch_pc,
    output logic        idle
);

    typedef enum logic {
        RUN  = 1'b0,
        DONE = 1'b1
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] pc;
    logic [31:0] pc_next;
    logic [1:0]  count;
    logic [31:0] slot_pc    [2];
    logic [31:0] slot_instr [2];
    logic        push;
    logic        pop;
    logic        unused_target_bits;

    assign unused_target_bits = ^redirect_target[1:0];

    // Redirect overrides both queue ends; state follows the PC it will hold.
    always_comb begin
        push    = 1'b0;
        pop     = 1'b0;
        pc_next = pc;
        if (redirect_valid) begin
            pc_next = {redirect_target[31:2], 2'b00};
        end else begin
            pop  = (count != 2'd0) && fetch_ready;
            push = (state == RUN) && ((count != 2'd2) || pop);
            if (push) begin
                pc_next = pc + 32'd4;
            end
        end
        state_next = (pc_next < PC_LIMIT) ? RUN : DONE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RUN;
            pc    <= RESET_PC;
            count <= '0;
        end else begin
            state <= state_next;
            pc    <= pc_next;
            if (redirect_valid) begin
                count <= '0;
            end else if (push && !pop) begin
                count <= count + 2'd1;
            end else if (pop && !push) begin
                count <= count - 2'd1;
            end
        end
    end

    // Payload needs no reset: occupancy alone qualifies the head.
    always_ff @(posedge clk) begin
        if (!redirect_valid) begin
            if (pop) begin
                slot_pc[0]    <= slot_pc[1];
                slot_instr[0] <= slot_instr[1];
            end
            if (push) begin
                if (pop) begin
                    if (count == 2'd2) begin
                        slot_pc[1]    <= IMEM_PC;
                        slot_instr[1] <= IMEM_instruction;
                    end else begin
                        slot_pc[0]    <= IMEM_PC;
                        slot_instr[0] <= IMEM_instruction;
                    end
                end else begin
                    slot_pc[count[0]]    <= IMEM_PC;
                    slot_instr[count[0]] <= IMEM_instruction;
                end
            end
        end
    end

    assign IMEM_PC     = pc;
    assign fetch_valid = (count != 2'd0);
    assign fetch_instr = fetch_valid ? slot_instr[0] : '0;
    assign fetch_pc    = fetch_valid ? slot_pc[0] : '0;
    assign idle        = (state == DONE) && (count == 2'd0);

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed scenarios plus random traffic, all checked
// against a queue-based reference of the fetch/decode handshake.
module tb_fetch_ctrl;

    localparam logic [31:0] RST_PC = 32'd0;
    localparam logic [31:0] LIMIT  = 32'd44;

    logic        clk;
    logic        reset;
    logic [31:0] imem_pc;
    logic [31:0] imem_instruction;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        fetch_valid;
    logic        fetch_ready;
    logic [31:0] fetch_instr;
    logic [31:0] fetch_pc;
    logic        idle;

    int unsigned total;
    int unsigned bad;

    logic [31:0] rom [11];
    logic [31:0] q_pc [$];
    logic [31:0] q_in [$];
    logic [31:0] m_pc;

    fetch_ctrl #(
        .RESET_PC(RST_PC),
        .PC_LIMIT(LIMIT)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .IMEM_PC         (imem_pc),
        .IMEM_instruction(imem_instruction),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .fetch_valid     (fetch_valid),
        .fetch_ready     (fetch_ready),
        .fetch_instr     (fetch_instr),
        .fetch_pc        (fetch_pc),
        .idle            (idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a < LIMIT) return rom[a[5:2]];
        return a ^ 32'hA5A5_0000;
    endfunction

    assign imem_instruction = mem_word(imem_pc);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Compare this cycle's outputs with the reference, then apply the inputs
    // for the coming edge and advance the reference across it.
    task automatic cycle(input logic r, input logic rv, input logic [31:0] t, input logic rdy);
        logic do_pop;
        logic do_push;
        logic have;
        @(negedge clk);
        have = (q_pc.size() != 0);
        check("valid", {31'd0, fetch_valid}, {31'd0, have});
        check("pc", fetch_pc, have ? q_pc[0] : 32'd0);
        check("instr", fetch_instr, have ? q_in[0] : 32'd0);
        check("imem_pc", imem_pc, m_pc);
        check("idle", {31'd0, idle}, {31'd0, (m_pc >= LIMIT) && !have});
        reset           = r;
        redirect_valid  = rv;
        redirect_target = t;
        fetch_ready     = rdy;
        if (r) begin
            q_pc.delete();
            q_in.delete();
            m_pc = RST_PC;
        end else if (rv) begin
            q_pc.delete();
            q_in.delete();
            m_pc = t & 32'hFFFF_FFFC;
        end else begin
            do_pop  = have && rdy;
            do_push = (m_pc < LIMIT) && ((q_pc.size() < 2) || do_pop);
            if (do_pop) begin
                void'(q_pc.pop_front());
                void'(q_in.pop_front());
            end
            if (do_push) begin
                q_pc.push_back(m_pc);
                q_in.push_back(mem_word(m_pc));
                m_pc = m_pc + 32'd4;
            end
        end
    endtask

    initial begin
        logic found;
        logic [31:0] tgt;
        total = 0;
        bad   = 0;
        rom[0]  = 32'h20090001; rom[1]  = 32'h200A000A; rom[2]  = 32'h21290001;
        rom[3]  = 32'h012A582A; rom[4]  = 32'h214AFFFF; rom[5]  = 32'h1168FFFC;
        rom[6]  = 32'h08000002; rom[7]  = 32'hAC0B0000; rom[8]  = 32'h8C0C0000;
        rom[9]  = 32'h016C6820; rom[10] = 32'h0800000A;
        reset = 1'b1; redirect_valid = 1'b0; redirect_target = '0; fetch_ready = 1'b1;
        @(negedge clk);
        q_pc.delete(); q_in.delete(); m_pc = RST_PC;

        // streaming after reset, then redirect back to 8 from pc 20
        cycle(1, 0, 0, 1);
        cycle(0, 0, 0, 1);
        check("rst_valid", {31'd0, fetch_valid}, 32'd0);
        check("rst_imem", imem_pc, 32'd0);
        check("rst_idle", {31'd0, idle}, 32'd0);
        cycle(0, 0, 0, 1);
        check("s_pc0", fetch_pc, 32'd0);
        check("s_in0", fetch_instr, 32'h20090001);
        cycle(0, 0, 0, 1);
        check("s_pc4", fetch_pc, 32'd4);
        check("s_in4", fetch_instr, 32'h200A000A);
        repeat (3) cycle(0, 0, 0, 1);
        cycle(0, 1, 32'd8, 1);
        check("r_pc20", fetch_pc, 32'd20);
        check("r_in20", fetch_instr, 32'h1168FFFC);
        cycle(0, 0, 0, 1);
        check("r_bubble", {31'd0, fetch_valid}, 32'd0);
        cycle(0, 0, 0, 1);
        check("r_pc8", fetch_pc, 32'd8);
        check("r_in8", fetch_instr, 32'h21290001);

        // backpressure fills the queue, then drains in order
        cycle(1, 0, 0, 0);
        repeat (5) cycle(0, 0, 0, 0);
        check("bp_valid", {31'd0, fetch_valid}, 32'd1);
        check("bp_pc", fetch_pc, 32'd0);
        check("bp_imem", imem_pc, 32'd8);
        cycle(0, 0, 0, 1);
        check("bp_d0", fetch_pc, 32'd0);
        cycle(0, 0, 0, 1);
        check("bp_d4", fetch_pc, 32'd4);
        cycle(0, 0, 0, 1);
        check("bp_d8", fetch_pc, 32'd8);

        // reset while full and stalled
        cycle(0, 0, 0, 0);
        cycle(0, 0, 0, 0);
        cycle(0, 0, 0, 0);
        cycle(1, 0, 0, 0);
        cycle(0, 0, 0, 1);
        check("fr_valid", {31'd0, fetch_valid}, 32'd0);
        check("fr_imem", imem_pc, 32'd0);
        check("fr_idle", {31'd0, idle}, 32'd0);
        cycle(0, 0, 0, 1);
        check("fr_pc0", fetch_pc, 32'd0);
        cycle(0, 0, 0, 1);
        check("fr_pc4", fetch_pc, 32'd4);

        // run to the end, go idle, redirect back to 0
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            cycle(0, 0, 0, 1);
            found = fetch_valid && (fetch_pc == 32'd40);
        end
        check("end_reached", {31'd0, found}, 32'd1);
        cycle(0, 1, 32'd0, 1);
        check("end_valid", {31'd0, fetch_valid}, 32'd0);
        check("end_imem", imem_pc, 32'd44);
        check("end_idle", {31'd0, idle}, 32'd1);
        cycle(0, 0, 0, 1);
        check("wake_idle", {31'd0, idle}, 32'd0);
        cycle(0, 0, 0, 1);
        check("wake_pc0", fetch_pc, 32'd0);

        // unaligned target is truncated to a word address
        cycle(0, 1, 32'h0000000E, 1);
        cycle(0, 0, 0, 1);
        cycle(0, 0, 0, 1);
        check("ua_pc", fetch_pc, 32'd12);
        check("ua_in", fetch_instr, 32'h012A582A);

        // redirect beyond the limit parks the fetcher
        cycle(0, 1, 32'd100, 1);
        cycle(0, 0, 0, 1);
        check("far_idle", {31'd0, idle}, 32'd1);

        // random traffic
        for (int i = 0; i < 600; i++) begin
            case ($urandom_range(0, 9))
                0:       tgt = 32'hFFFF_FFFC;
                1:       tgt = $urandom();
                default: tgt = $urandom_range(0, 63);
            endcase
            cycle(($urandom_range(0, 39) == 0), ($urandom_range(0, 7) == 0), tgt,
                  ($urandom_range(0, 2) != 0));
        end
        cycle(0, 0, 0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
